// File: rtl/dmem_dma_master.sv
// Word-copy bus initiator for the data-memory bus (CPU/DMA arbitrated).
// Optional level interrupt enabled by defining DMA_IRQ_EN.
module dmem_dma_master #(
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] word_cnt,
  input  logic             bus_gnt,
  input  logic [31:0]      mem_rdata,
  output logic             bus_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             irq,
  input  logic             irq_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      src_q, dst_q, buf_q;
  logic [LEN_W-1:0] cnt_q;
  logic             err_q;
  logic             misaligned;
  logic             start_acc;

  assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
  assign start_acc  = (state == S_IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) begin
                 if (misaligned || (word_cnt == '0)) state_nx = S_DONE;
                 else                                state_nx = S_REQ;
               end
      S_REQ:   if (bus_gnt) state_nx = S_READ;
      S_READ:  if (bus_gnt) state_nx = S_WRITE;
      // Without a grant the phase simply holds, so the post-write choice is only DONE or READ
      S_WRITE: if (bus_gnt) state_nx = (cnt_q == LEN_W'(1)) ? S_DONE : S_READ;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      buf_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          src_q <= src_addr;
          dst_q <= dst_addr;
          cnt_q <= word_cnt;
          err_q <= misaligned;
        end
        S_READ:  if (bus_gnt) buf_q <= mem_rdata;
        S_WRITE: if (bus_gnt) begin
          src_q <= src_q + 32'd4;
          dst_q <= dst_q + 32'd4;
          cnt_q <= cnt_q - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      S_REQ: bus_req = 1'b1;
      S_READ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          mem_read = 1'b1;
          mem_addr = src_q;
        end
      end
      S_WRITE: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          mem_write = 1'b1;
          mem_addr  = dst_q;
          mem_wdata = buf_q;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign err  = err_q;

`ifdef DMA_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       irq_q <= 1'b0;
    else if (state == S_DONE)        irq_q <= 1'b1;
    else if (irq_clr || start_acc)   irq_q <= 1'b0;
  end
  assign irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr & start_acc;
  assign irq = 1'b0;
`endif

endmodule
